// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions (active-low, seg[6]=a ... seg[0]=g).
// Used by both the hex-to-segment encoder and the capture monitor.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the hex-to-segment encoder table.
// Any pattern outside the table (blank included) is flagged illegal and decodes to 0.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       nibble,
    output logic             legal
);

    // Table lookup; default covers every illegal pattern
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (seg)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment bus monitor: qualifies each anode dwell, decodes it back to a nibble,
// assembles frames and publishes the value after STABLE_SCANS identical legal frames.
// Optional macro SEG7_CAPTURE_SYNC_EN adds 2-flop input synchronizers for async probing.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STABLE_SCANS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEG_W-1:0]      seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   hex_value,
    output logic                  value_valid,
    output logic                  value_update,
    output logic                  pattern_err,
    output logic [DIGITS-1:0]     err_digit
);

    localparam int OW = SEG_W + DIGITS;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW = $clog2(STABLE_SCANS + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(STABLE_SCANS);

    logic [OW-1:0] obs;

`ifdef SEG7_CAPTURE_SYNC_EN
    logic [OW-1:0] sync1, sync2;

    // Two-flop synchronizer; resets to blanked bus so nothing qualifies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {an, seg};
            sync2 <= sync1;
        end
    end
    assign obs = sync2;
`else
    assign obs = {an, seg};
`endif

    logic [DIGITS-1:0] an_s;
    logic [SEG_W-1:0]  seg_s;
    assign an_s  = obs[SEG_W +: DIGITS];
    assign seg_s = obs[SEG_W-1:0];

    logic [OW-1:0]     prev_obs;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              captured;
    logic              an_valid, changed, sample, complete;
    logic [DIGITS-1:0] sel;
    logic [3:0]        dec_nib;
    logic              dec_legal;

    seg7_decode u_decode (
        .seg    (seg_s),
        .nibble (dec_nib),
        .legal  (dec_legal)
    );

    assign an_valid = $onehot(~an_s);
    assign sel      = an_valid ? ~an_s : '0;
    assign changed  = (obs != prev_obs);

    // Settle counter next state and the single-sample-per-dwell decision
    always_comb begin
        cnt_d = '0;
        if (!an_valid)                cnt_d = '0;
        else if (changed)             cnt_d = CW'(1);
        else if (cnt_q < SETTLE_MAX)  cnt_d = cnt_q + CW'(1);
        else                          cnt_d = cnt_q;
        sample = an_valid && (cnt_d == SETTLE_MAX) && !(captured && !changed);
    end

    // Dwell tracking state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_obs <= '1;
            cnt_q    <= '0;
            captured <= 1'b0;
        end else begin
            prev_obs <= obs;
            cnt_q    <= cnt_d;
            if (sample)       captured <= 1'b1;
            else if (changed) captured <= 1'b0;
        end
    end

    logic [DIGITS-1:0]   slot_mask;
    logic [3:0]          slot_nib [DIGITS];
    logic [DIGITS-1:0]   slot_err;
    logic [4*DIGITS-1:0] frame;
    logic [DIGITS-1:0]   frame_err;

    // Current frame view including the sample being written this cycle
    always_comb begin
        frame     = '0;
        frame_err = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sample && sel[i]) begin
                frame[4*i +: 4] = dec_nib;
                frame_err[i]    = !dec_legal;
            end else begin
                frame[4*i +: 4] = slot_nib[i];
                frame_err[i]    = slot_err[i];
            end
        end
        complete = sample && ((slot_mask | sel) == {DIGITS{1'b1}});
    end

    // Slot storage; mask clears on the completing sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_mask <= '0;
            slot_err  <= '0;
            for (int i = 0; i < DIGITS; i++) slot_nib[i] <= 4'h0;
        end else if (sample) begin
            slot_mask <= complete ? '0 : (slot_mask | sel);
            for (int i = 0; i < DIGITS; i++) begin
                if (sel[i]) begin
                    slot_nib[i] <= dec_legal ? dec_nib : 4'h0;
                    slot_err[i] <= !dec_legal;
                end
            end
        end
    end

    logic [4*DIGITS-1:0] prev_frame;
    logic [MW-1:0]       match_q, match_d;
    logic                publish;

    // Match count next state for a completing frame
    always_comb begin
        match_d = '0;
        if (|frame_err)                match_d = '0;
        else if (frame == prev_frame)  match_d = (match_q < MATCH_MAX) ? match_q + MW'(1) : match_q;
        else                           match_d = MW'(1);
        publish = complete && !(|frame_err) && (match_d == MATCH_MAX);
    end

    // Frame evaluation and published outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_frame   <= '0;
            match_q      <= '0;
            hex_value    <= '0;
            value_valid  <= 1'b0;
            value_update <= 1'b0;
            pattern_err  <= 1'b0;
            err_digit    <= '0;
        end else begin
            value_update <= 1'b0;
            pattern_err  <= 1'b0;
            if (complete) begin
                err_digit   <= frame_err;
                pattern_err <= |frame_err;
                match_q     <= match_d;
                prev_frame  <= frame;
            end
            if (publish) begin
                hex_value    <= frame;
                value_valid  <= 1'b1;
                value_update <= (frame != hex_value) || !value_valid;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture at default parameters.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'b1111111;
    logic [3:0]  an  = 4'b1111;
    logic [15:0] hex_value;
    logic        value_valid, value_update, pattern_err;
    logic [3:0]  err_digit;

    int checks = 0;
    int passed = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    seg7_capture dut (
        .clk          (clk),
        .rst          (rst),
        .seg          (seg),
        .an           (an),
        .hex_value    (hex_value),
        .value_valid  (value_valid),
        .value_update (value_update),
        .pattern_err  (pattern_err),
        .err_digit    (err_digit)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (value_update === 1'b1) upd_cnt = upd_cnt + 1;
        if (pattern_err === 1'b1)  err_cnt = err_cnt + 1;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'b0000001;  4'h1: seg_of = 7'b1001111;
            4'h2: seg_of = 7'b0010010;  4'h3: seg_of = 7'b0000110;
            4'h4: seg_of = 7'b1001100;  4'h5: seg_of = 7'b0100100;
            4'h6: seg_of = 7'b0100000;  4'h7: seg_of = 7'b0001111;
            4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0000100;
            4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b1100000;
            4'hC: seg_of = 7'b0110001;  4'hD: seg_of = 7'b1000010;
            4'hE: seg_of = 7'b0110000;  default: seg_of = 7'b0111000;
        endcase
    endfunction

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int cycles);
        an  = a;
        seg = s;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic dwell(input int d, input logic [6:0] s, input int cycles);
        logic [3:0] a;
        a = 4'b1111;
        a[d] = 1'b0;
        hold(a, s, cycles);
    endtask

    task automatic send_frame(input logic [15:0] v);
        for (int i = 0; i < 4; i++) dwell(i, seg_of(v[4*i +: 4]), 8);
        hold(4'b1111, 7'b1111111, 2);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (hex_value !== 16'h0) $display("FAIL reset_hex: got %h, expected 0", hex_value); else passed++;
        if (value_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", value_valid); else passed++;
        if (value_update !== 1'b0) $display("FAIL reset_update: got %b, expected 0", value_update); else passed++;
        if (pattern_err !== 1'b0) $display("FAIL reset_perr: got %b, expected 0", pattern_err); else passed++;
        if (err_digit !== 4'h0) $display("FAIL reset_errdig: got %b, expected 0", err_digit); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        upd_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic test_basic();
        send_frame(16'h4321);
        checks += 1;
        if (value_valid !== 1'b0) $display("FAIL basic_no_early: valid %b, expected 0", value_valid); else passed++;
        send_frame(16'h4321);
        checks += 3;
        if (hex_value !== 16'h4321) $display("FAIL basic_hex: got %h, expected 4321", hex_value); else passed++;
        if (value_valid !== 1'b1) $display("FAIL basic_valid: got %b, expected 1", value_valid); else passed++;
        if (upd_cnt != 1) $display("FAIL basic_update: got %0d pulses, expected 1", upd_cnt); else passed++;
        send_frame(16'h4321);
        checks += 1;
        if (upd_cnt != 1) $display("FAIL basic_repeat: got %0d pulses, expected 1", upd_cnt); else passed++;
    endtask

    task automatic test_short_dwell();
        int u0;
        u0 = upd_cnt;
        dwell(0, seg_of(4'h1), 8);
        dwell(1, seg_of(4'h2), 8);
        dwell(2, seg_of(4'h9), 3);
        dwell(3, seg_of(4'h4), 8);
        hold(4'b1111, 7'b1111111, 3);
        checks += 2;
        if (hex_value !== 16'h4321) $display("FAIL short_hex: got %h, expected 4321", hex_value); else passed++;
        if (upd_cnt != u0) $display("FAIL short_update: got %0d pulses, expected %0d", upd_cnt, u0); else passed++;
        // Filling slot 2 completes the pending frame as 4321 again
        dwell(2, seg_of(4'h3), 8);
        checks += 2;
        if (hex_value !== 16'h4321) $display("FAIL short_fill_hex: got %h, expected 4321", hex_value); else passed++;
        if (err_cnt != 0) $display("FAIL short_perr: got %0d pulses, expected 0", err_cnt); else passed++;
    endtask

    task automatic test_pattern_err();
        int u0;
        u0 = upd_cnt;
        dwell(0, seg_of(4'h1), 8);
        dwell(1, 7'b1111111, 8);
        dwell(2, seg_of(4'h3), 8);
        dwell(3, seg_of(4'h4), 8);
        hold(4'b1111, 7'b1111111, 2);
        checks += 4;
        if (err_cnt != 1) $display("FAIL perr_pulse: got %0d pulses, expected 1", err_cnt); else passed++;
        if (err_digit !== 4'b0010) $display("FAIL perr_mask: got %b, expected 0010", err_digit); else passed++;
        if (hex_value !== 16'h4321) $display("FAIL perr_hex: got %h, expected 4321", hex_value); else passed++;
        if (upd_cnt != u0) $display("FAIL perr_update: got %0d, expected %0d", upd_cnt, u0); else passed++;
        send_frame(16'hABCD);
        checks += 1;
        if (hex_value !== 16'h4321) $display("FAIL abcd_early: got %h, expected 4321", hex_value); else passed++;
        send_frame(16'hABCD);
        checks += 3;
        if (hex_value !== 16'hABCD) $display("FAIL abcd_hex: got %h, expected abcd", hex_value); else passed++;
        if (err_digit !== 4'b0000) $display("FAIL abcd_mask: got %b, expected 0000", err_digit); else passed++;
        if (upd_cnt != u0 + 1) $display("FAIL abcd_update: got %0d, expected %0d", upd_cnt, u0 + 1); else passed++;
    endtask

    task automatic glitch_frame();
        hold(4'b1100, seg_of(4'h0), 8);
        dwell(0, seg_of(4'h8), 8);
        hold(4'b1111, seg_of(4'h0), 8);
        dwell(1, seg_of(4'h7), 8);
        dwell(2, seg_of(4'h6), 2);
        dwell(2, seg_of(4'h0), 1);
        dwell(2, seg_of(4'h6), 8);
        hold(4'b0110, seg_of(4'h1), 8);
        dwell(3, seg_of(4'h5), 8);
        hold(4'b1111, 7'b1111111, 2);
    endtask

    task automatic test_glitch();
        int u0;
        u0 = upd_cnt;
        glitch_frame();
        glitch_frame();
        checks += 3;
        if (hex_value !== 16'h5678) $display("FAIL glitch_hex: got %h, expected 5678", hex_value); else passed++;
        if (upd_cnt != u0 + 1) $display("FAIL glitch_update: got %0d, expected %0d", upd_cnt, u0 + 1); else passed++;
        if (err_cnt != 1) $display("FAIL glitch_perr: got %0d, expected 1", err_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        dwell(0, seg_of(4'hF), 8);
        dwell(1, seg_of(4'h0), 8);
        dwell(2, seg_of(4'hF), 8);
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (hex_value !== 16'h0) $display("FAIL rmid_hex: got %h, expected 0", hex_value); else passed++;
        if (value_valid !== 1'b0) $display("FAIL rmid_valid: got %b, expected 0", value_valid); else passed++;
        if (err_digit !== 4'h0) $display("FAIL rmid_errdig: got %b, expected 0", err_digit); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        hold(4'b1111, 7'b1111111, 2);
        upd_cnt = 0;
        send_frame(16'h0F0F);
        checks += 1;
        if (value_valid !== 1'b0) $display("FAIL rmid_one_frame: valid %b, expected 0", value_valid); else passed++;
        send_frame(16'h0F0F);
        checks += 3;
        if (hex_value !== 16'h0F0F) $display("FAIL rmid_pub_hex: got %h, expected 0f0f", hex_value); else passed++;
        if (value_valid !== 1'b1) $display("FAIL rmid_pub_valid: got %b, expected 1", value_valid); else passed++;
        if (upd_cnt != 1) $display("FAIL rmid_update: got %0d, expected 1", upd_cnt); else passed++;
    endtask

    task automatic test_alternating();
        send_frame(16'h1111);
        send_frame(16'h2222);
        send_frame(16'h1111);
        send_frame(16'h2222);
        checks += 2;
        if (hex_value !== 16'h0F0F) $display("FAIL alt_hex: got %h, expected 0f0f", hex_value); else passed++;
        if (upd_cnt != 1) $display("FAIL alt_update: got %0d, expected 1", upd_cnt); else passed++;
        send_frame(16'h2222);
        checks += 2;
        if (hex_value !== 16'h2222) $display("FAIL alt_pub_hex: got %h, expected 2222", hex_value); else passed++;
        if (upd_cnt != 2) $display("FAIL alt_pub_update: got %0d, expected 2", upd_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_dwell();
        test_pattern_err();
        test_glitch();
        test_reset_mid();
        test_alternating();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
